seg7_scan_ctrl: RTL and testbench

- Time-multiplexing scheduler for the board's 8-digit common-anode 7-segment display.
- Shares a single A2G/DP segment bus between eight digits: round-robin digit scan, inter-digit blanking to stop ghosting, and frame-synchronous update of displayed data so a CPU store never causes a torn frame.
- Instantiated inside the data-memory I/O decoder; driven by CPU stores to the display register.

---
 rtl/seg7_scan_ctrl_pkg.sv | 17 +
 rtl/seg7_scan_ctrl_if.sv | 17 +
 rtl/seg7_scan_ctrl_decode.sv | 9 +
 rtl/seg7_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan controller.
// Segment patterns are active low, ordered a..g with g in bit 0.
package seg7_pkg;

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [0:15][6:0] SEG_TBL = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// CPU-side store/mask inputs and display-side outputs of the scan controller.
// The master drives stores and masks; the slave (controller) drives the display pins.
interface seg7_scan_ctrl_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_en;
  logic [7:0]  AN;
  logic [6:0]  A2G;
  logic        DP;
  logic        frame_done;

  modport master (output wr_en, wr_data, dp_mask, digit_en,
                  input  AN, A2G, DP, frame_done);
  modport slave  (input  wr_en, wr_data, dp_mask, digit_en,
                  output AN, A2G, DP, frame_done);
endinterface

// File: rtl/seg7_scan_ctrl_decode.sv
// Combinational hex nibble to active-low a..g segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_TBL[i_nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Round-robin 8-digit scan with inter-digit blanking and frame-synchronous data update.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 100
)(
  input  logic            clk,
  input  logic            reset,
  seg7_scan_ctrl_if.slave bus
);
  localparam int DIV  = CLK_HZ / DIGIT_HZ;
  localparam int CMAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_dig, w_dig_nx;
  logic [31:0]   r_shown, r_pend;
  logic          r_pv;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp, r_fd;

  logic          w_boundary, w_fd_nx, w_lit;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_dec;
  logic [7:0]    w_lzb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SHOW;
      r_cnt   <= '0;
      r_dig   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dig   <= w_dig_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CW'(1);
    w_dig_nx   = r_dig;
    case (r_state)
      SHOW: if (r_cnt == SHOW_LAST) begin
        w_state_nx = BLANK;
        w_cnt_nx   = '0;
      end
      BLANK: if (r_cnt == BLANK_LAST) begin
        w_state_nx = SHOW;
        w_cnt_nx   = '0;
        w_dig_nx   = r_dig + 3'd1;
      end
      default: w_state_nx = SHOW;
    endcase
  end

  // The boundary is the last blank cycle of digit 7; frame_done is registered
  // one cycle ahead so the pulse lines up with that cycle, letting a store
  // seen alongside the pulse take the bypass path.
  assign w_boundary = (r_state == BLANK) && (r_cnt == BLANK_LAST) && (r_dig == 3'd7);
  assign w_fd_nx    = (w_state_nx == BLANK) && (w_cnt_nx == BLANK_LAST) && (w_dig_nx == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shown <= '0;
      r_pend  <= '0;
      r_pv    <= 1'b0;
    end else if (w_boundary) begin
      if (bus.wr_en)  r_shown <= bus.wr_data;
      else if (r_pv)  r_shown <= r_pend;
      r_pv <= 1'b0;
    end else if (bus.wr_en) begin
      r_pend <= bus.wr_data;
      r_pv   <= 1'b1;
    end
  end

`ifdef SEG7_LZB_EN
  // Digit i is blanked when it and every higher nibble are zero; digit 0 never.
  always_comb begin
    logic zero_above;
    w_lzb      = '0;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above = zero_above && (r_shown[4*i +: 4] == 4'h0);
      w_lzb[i]   = zero_above;
    end
  end
`else
  assign w_lzb = '0;
`endif

  assign w_nib = r_shown[{r_dig, 2'b00} +: 4];

  seg7_decode u_dec (.i_nib(w_nib), .o_seg(w_seg_dec));

  assign w_lit = (r_state == SHOW) && bus.digit_en[r_dig] && !w_lzb[r_dig];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
      r_fd  <= 1'b0;
    end else begin
      r_an  <= w_lit ? ~(8'd1 << r_dig) : AN_OFF;
      r_seg <= w_lit ? w_seg_dec : SEG_OFF;
      r_dp  <= w_lit ? ~bus.dp_mask[r_dig] : 1'b1;
      r_fd  <= w_fd_nx;
    end
  end

  assign bus.AN         = r_an;
  assign bus.A2G        = r_seg;
  assign bus.DP         = r_dp;
  assign bus.frame_done = r_fd;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: time-indexed display model plus directed scenario checks.
module tb_seg7_scan_ctrl;
  localparam int DIV   = 10;
  localparam int BL    = 2;
  localparam int SLOT  = DIV + BL;
  localparam int FRAME = 8 * SLOT;
`ifdef SEG7_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  localparam logic [6:0] TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.CLK_HZ(100), .DIGIT_HZ(10), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Model: cycle mc since reset release determines slot and phase directly.
  int unsigned mc = 0;
  logic [31:0] m_shown = '0, m_pend = '0;
  bit          m_pv = 1'b0;
  logic [7:0]  e_an = 8'hFF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1, e_fd = 1'b0;
  bit          chk_en = 1'b0;
  int          mp, mdg;

  function automatic bit lzb_blank(logic [31:0] v, int dg);
    return LZB_EN && (dg != 0) && ((v >> (4 * dg)) == 32'd0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mc = 0; m_shown = '0; m_pend = '0; m_pv = 1'b0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      mp  = int'(mc % FRAME);
      mdg = mp / SLOT;
      if ((mp % SLOT) < DIV && bus.digit_en[mdg] && !lzb_blank(m_shown, mdg)) begin
        e_an  = ~(8'd1 << mdg);
        e_seg = TBL[m_shown[4*mdg +: 4]];
        e_dp  = ~bus.dp_mask[mdg];
      end else begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      e_fd = ((mc + 1) % FRAME) == FRAME - 1;
      if (mp == FRAME - 1) begin
        if (bus.wr_en) m_shown = bus.wr_data;
        else if (m_pv) m_shown = m_pend;
        m_pv = 1'b0;
      end else if (bus.wr_en) begin
        m_pend = bus.wr_data;
        m_pv   = 1'b1;
      end
      mc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({bus.AN, bus.A2G, bus.DP, bus.frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        fails++;
        $display("FAIL model c=%0d got AN=%h A2G=%b DP=%b fd=%b want AN=%h A2G=%b DP=%b fd=%b",
                 mc, bus.AN, bus.A2G, bus.DP, bus.frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
  end

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_an(input logic [7:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (bus.AN === v) begin ok = 1'b1; break; end
    end
  endtask

  task automatic store(input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.AN, bus.A2G, bus.DP, bus.frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset_hold got AN=%h A2G=%b DP=%b fd=%b", bus.AN, bus.A2G, bus.DP, bus.frame_done);
    end
    chk_en = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < SLOT; i++) begin
      @(negedge clk);
      tests++;
      if (bus.AN !== ((i < DIV) ? 8'hFE : 8'hFF)) begin
        fails++; $display("FAIL reset_release_seq i=%0d got AN=%h", i, bus.AN);
      end
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({bus.AN, bus.A2G, bus.DP, bus.frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset_async got AN=%h A2G=%b DP=%b", bus.AN, bus.A2G, bus.DP);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_scan();
    bit ok;
    int n;
    store(32'h76543210);
    wait_fd(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL scan_wait_fd got timeout want pulse"); end
    @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < SLOT; k++) begin
        @(negedge clk);
        tests++;
        if (k < DIV) begin
          if (bus.AN !== ~(8'd1 << d) || bus.A2G !== TBL[d]) begin
            fails++; $display("FAIL scan_walk d=%0d got AN=%h A2G=%b want AN=%h A2G=%b", d, bus.AN, bus.A2G, ~(8'd1 << d), TBL[d]);
          end
        end else if (bus.AN !== 8'hFF) begin
          fails++; $display("FAIL scan_blank d=%0d got AN=%h want ff", d, bus.AN);
        end
      end
    end
    wait_fd(ok);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.frame_done !== 1'b1 && n < 3 * FRAME);
    tests++;
    if (n != FRAME) begin fails++; $display("FAIL frame_period got %0d want %0d", n, FRAME); end
  endtask

  task automatic test_tear();
    bit ok;
    wait_fd(ok);
    wait_an(8'hF7, ok);
    store(32'h11111111);
    wait_an(8'hDF, ok);
    tests++;
    if (!ok || bus.A2G !== TBL[5]) begin fails++; $display("FAIL tear_d5 got %b want %b", bus.A2G, TBL[5]); end
    wait_an(8'h7F, ok);
    tests++;
    if (!ok || bus.A2G !== TBL[7]) begin fails++; $display("FAIL tear_d7 got %b want %b", bus.A2G, TBL[7]); end
    wait_fd(ok);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.AN !== 8'hFE || bus.A2G !== TBL[1]) begin fails++; $display("FAIL tear_new got AN=%h A2G=%b", bus.AN, bus.A2G); end
    store(32'hAAAAAAA3);
    repeat (20) @(negedge clk);
    store(32'h0000000C);
    wait_fd(ok);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.A2G !== TBL[12]) begin fails++; $display("FAIL last_store_wins got %b want %b", bus.A2G, TBL[12]); end
  endtask

  task automatic test_bypass();
    bit ok;
    wait_fd(ok);
    bus.wr_en = 1'b1; bus.wr_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.AN !== 8'hFE || bus.A2G !== 7'b0111000) begin
      fails++; $display("FAIL bypass got AN=%h A2G=%b want fe 0111000", bus.AN, bus.A2G);
    end
  endtask

  task automatic test_masks();
    bit ok;
    int hi_lit, lo_lit, dp0, dp_other;
    bus.digit_en = 8'h0F; bus.dp_mask = 8'h01;
    wait_fd(ok);
    hi_lit = 0; lo_lit = 0; dp0 = 0; dp_other = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (bus.AN[7:4] !== 4'hF) hi_lit++;
      if (bus.AN[3:0] !== 4'hF) lo_lit++;
      if (bus.DP === 1'b0) begin
        if (bus.AN === 8'hFE) dp0++; else dp_other++;
      end
    end
    tests++;
    if (hi_lit != 0 || lo_lit != 4 * DIV) begin fails++; $display("FAIL mask_digits got hi=%0d lo=%0d want 0 %0d", hi_lit, lo_lit, 4 * DIV); end
    tests++;
    if (dp0 != DIV || dp_other != 0) begin fails++; $display("FAIL mask_dp got slot0=%0d other=%0d want %0d 0", dp0, dp_other, DIV); end
    bus.digit_en = 8'hFF; bus.dp_mask = 8'h00;
  endtask

`ifdef SEG7_LZB_EN
  task automatic test_lzb();
    bit ok;
    int lit, hi, bad;
    store(32'h00000A00);
    wait_fd(ok);
    lit = 0; hi = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (bus.AN !== 8'hFF) lit++;
      if (bus.AN[7:3] !== 5'h1F) hi++;
    end
    tests++;
    if (lit != 3 * DIV || hi != 0) begin fails++; $display("FAIL lzb_a00 got lit=%0d hi=%0d want %0d 0", lit, hi, 3 * DIV); end
    store(32'h0);
    wait_fd(ok);
    lit = 0; bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (bus.AN !== 8'hFF) begin
        lit++;
        if (bus.AN !== 8'hFE || bus.A2G !== 7'b0000001) bad++;
      end
    end
    tests++;
    if (lit != DIV || bad != 0) begin fails++; $display("FAIL lzb_zero got lit=%0d bad=%0d want %0d 0", lit, bad, DIV); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(24, 0) == 0) begin
        bus.wr_en = 1'b1; bus.wr_data = $urandom;
      end else begin
        bus.wr_en = 1'b0;
      end
      if ($urandom_range(299, 0) == 0) begin
        bus.digit_en = 8'($urandom); bus.dp_mask = 8'($urandom);
      end
      if (i == 1500) begin
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0;
    bus.digit_en = 8'hFF; bus.dp_mask = 8'h00;
    test_reset();
    test_scan();
    test_tear();
    test_bypass();
    test_masks();
`ifdef SEG7_LZB_EN
    test_lzb();
`endif
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
